max_product_trellis_step: RTL and testbench

//  Computes one full max-product (max-log-MAP) backward step for all trellis

---
 rtl/max_product_trellis_step.sv | 245 ++++++++++++++++++++++++
 tb/tb_max_product_trellis_step.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_product_trellis_step.sv
`default_nettype none
// ============================================================================
//  Module      : max_product_trellis_step
//  Description : One max-product (max-log-MAP) backward trellis step over all
//                states. LANES states are processed per cycle, with saturating
//                signed arithmetic and valid/ready handshakes on both sides.
//                Optional macro NORMALIZE_EN adds a beta normalisation cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module max_product_trellis_step #(
    parameter  int BITS   = 16,
    parameter  int STATES = 4,
    parameter  int NIN    = 1,
    parameter  int NOUT   = 2,
    parameter  int LANES  = 1,
    localparam int SW     = (STATES > 1) ? $clog2(STATES) : 1,
    localparam int INSYM  = 2 ** NIN,
    localparam int NBM    = 2 ** NOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STATES*INSYM*SW-1:0]   trellis_next_state,
    input  logic [STATES*INSYM*NOUT-1:0] trellis_output,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBM*BITS-1:0]          branch_metric,
    input  logic [STATES*BITS-1:0]       AlphaMetric,
    input  logic [STATES*BITS-1:0]       OldBetaMetric,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [STATES*BITS-1:0]       BetaMetric,
    output logic [INSYM*BITS-1:0]        llr_out
);

    localparam int GROUPS = STATES / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] c_LAST_GRP = CW'(GROUPS - 1);
    localparam logic signed [BITS-1:0] c_MIN_METRIC = {1'b1, {(BITS-1){1'b0}}};
    localparam logic signed [BITS-1:0] c_MAX_METRIC = {1'b0, {(BITS-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_WB   = 3'd2,
        S_NORM = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // The most negative code is -inf: it absorbs any addend instead of being
    // pulled back into the finite range.
    function automatic logic signed [BITS-1:0] f_sat_add(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic [BITS:0] sum;
        sum = {a[BITS-1], a} + {b[BITS-1], b};
        if (a == c_MIN_METRIC || b == c_MIN_METRIC) begin
            return c_MIN_METRIC;
        end else if (sum[BITS] != sum[BITS-1]) begin
            return sum[BITS] ? c_MIN_METRIC : c_MAX_METRIC;
        end else begin
            return sum[BITS-1:0];
        end
    endfunction

`ifdef NORMALIZE_EN
    function automatic logic signed [BITS-1:0] f_sat_sub(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic [BITS:0] diff;
        diff = {a[BITS-1], a} - {b[BITS-1], b};
        if (a == c_MIN_METRIC) begin
            return c_MIN_METRIC;
        end else if (diff[BITS] != diff[BITS-1]) begin
            return diff[BITS] ? c_MIN_METRIC : c_MAX_METRIC;
        end else begin
            return diff[BITS-1:0];
        end
    endfunction
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic                    w_accept;

    logic signed [BITS-1:0]  r_bm       [NBM];
    logic signed [BITS-1:0]  r_alpha    [STATES];
    logic signed [BITS-1:0]  r_oldb     [STATES];
    logic [SW-1:0]           r_ns       [STATES*INSYM];
    logic [NOUT-1:0]         r_op       [STATES*INSYM];
    logic signed [BITS-1:0]  r_beta     [STATES];
    logic signed [BITS-1:0]  r_llr_acc  [INSYM];
    logic signed [BITS-1:0]  r_beta_out [STATES];
    logic signed [BITS-1:0]  r_llr_out  [INSYM];

    logic [SW-1:0]           w_lane_st  [LANES];
    logic signed [BITS-1:0]  w_m        [LANES][INSYM];
    logic signed [BITS-1:0]  w_path     [LANES][INSYM];
    logic signed [BITS-1:0]  w_grp_beta [LANES];
    logic signed [BITS-1:0]  w_llr_nxt  [INSYM];

    // In OUT the handshake with the sink frees the block in the same cycle,
    // so a waiting step can be accepted without an IDLE bubble.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_OUT) && out_ready);
    assign out_valid = (r_state == S_OUT);
    assign w_accept  = in_valid && in_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_st[l] = SW'(int'(r_cnt) * LANES + l);
        for (genvar u = 0; u < INSYM; u++) begin : g_sym
            logic [SW+NIN-1:0] w_bidx;
            assign w_bidx     = {w_lane_st[l], NIN'(u)};
            assign w_m[l][u]    = f_sat_add(r_bm[r_op[w_bidx]], r_oldb[r_ns[w_bidx]]);
            assign w_path[l][u] = f_sat_add(r_alpha[w_lane_st[l]], w_m[l][u]);
        end
    end

    // Strict '>' keeps the lowest u / lowest s on ties.
    always_comb begin
        w_llr_nxt = r_llr_acc;
        for (int l = 0; l < LANES; l++) begin
            w_grp_beta[l] = w_m[l][0];
            for (int u = 1; u < INSYM; u++) begin
                if (w_m[l][u] > w_grp_beta[l]) begin
                    w_grp_beta[l] = w_m[l][u];
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            for (int u = 0; u < INSYM; u++) begin
                if (w_path[l][u] > w_llr_nxt[u]) begin
                    w_llr_nxt[u] = w_path[l][u];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_LAST_GRP) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
`ifdef NORMALIZE_EN
                w_state_nxt = S_NORM;
`else
                w_state_nxt = S_OUT;
`endif
            end
            S_NORM: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            for (int i = 0; i < NBM; i++) begin
                r_bm[i] <= '0;
            end
            for (int i = 0; i < STATES; i++) begin
                r_alpha[i]    <= '0;
                r_oldb[i]     <= '0;
                r_beta[i]     <= '0;
                r_beta_out[i] <= '0;
            end
            for (int i = 0; i < STATES*INSYM; i++) begin
                r_ns[i] <= '0;
                r_op[i] <= '0;
            end
            for (int i = 0; i < INSYM; i++) begin
                r_llr_acc[i] <= '0;
                r_llr_out[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
                for (int i = 0; i < NBM; i++) begin
                    r_bm[i] <= branch_metric[i*BITS +: BITS];
                end
                for (int i = 0; i < STATES; i++) begin
                    r_alpha[i] <= AlphaMetric[i*BITS +: BITS];
                    r_oldb[i]  <= OldBetaMetric[i*BITS +: BITS];
                end
                for (int i = 0; i < STATES*INSYM; i++) begin
                    r_ns[i] <= trellis_next_state[i*SW +: SW];
                    r_op[i] <= trellis_output[i*NOUT +: NOUT];
                end
                for (int i = 0; i < INSYM; i++) begin
                    r_llr_acc[i] <= c_MIN_METRIC;
                end
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
                for (int l = 0; l < LANES; l++) begin
                    r_beta[w_lane_st[l]] <= w_grp_beta[l];
                end
                r_llr_acc <= w_llr_nxt;
            end
            // Results move to the output registers only once complete, so
            // the outputs never show a partially computed step.
            if (r_state == S_WB) begin
                r_beta_out <= r_beta;
                r_llr_out  <= r_llr_acc;
            end
`ifdef NORMALIZE_EN
            if (r_state == S_NORM) begin
                for (int i = 0; i < STATES; i++) begin
                    r_beta_out[i] <= f_sat_sub(r_beta_out[i], r_beta_out[0]);
                end
            end
`endif
        end
    end

    for (genvar s = 0; s < STATES; s++) begin : g_pack_beta
        assign BetaMetric[s*BITS +: BITS] = r_beta_out[s];
    end

    for (genvar u = 0; u < INSYM; u++) begin : g_pack_llr
        assign llr_out[u*BITS +: BITS] = r_llr_out[u];
    end

endmodule
`default_nettype wire

// File: tb/tb_max_product_trellis_step.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_product_trellis_step
//  Description : Scoreboard bench for max_product_trellis_step (LANES=1,
//                RSC {5,7}/7 trellis plus random tables). Honours NORMALIZE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_max_product_trellis_step;

    localparam int BITS   = 16;
    localparam int STATES = 4;
    localparam int NIN    = 1;
    localparam int NOUT   = 2;
    localparam int LANES  = 1;
    localparam int INSYM  = 2;
    localparam int NBM    = 4;
    localparam int SW     = 2;
    localparam int MINV   = -32768;
    localparam int MAXV   = 32767;
`ifdef NORMALIZE_EN
    localparam int LAT = STATES / LANES + 2;
`else
    localparam int LAT = STATES / LANES + 1;
`endif

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic [STATES*INSYM*SW-1:0]   trellis_next_state = '0;
    logic [STATES*INSYM*NOUT-1:0] trellis_output = '0;
    logic                         in_valid = 1'b0;
    logic                         in_ready;
    logic [NBM*BITS-1:0]          branch_metric = '0;
    logic [STATES*BITS-1:0]       AlphaMetric = '0;
    logic [STATES*BITS-1:0]       OldBetaMetric = '0;
    logic                         out_valid;
    logic                         out_ready = 1'b1;
    logic [STATES*BITS-1:0]       BetaMetric;
    logic [INSYM*BITS-1:0]        llr_out;

    max_product_trellis_step #(
        .BITS(BITS), .STATES(STATES), .NIN(NIN), .NOUT(NOUT), .LANES(LANES)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .trellis_next_state (trellis_next_state),
        .trellis_output     (trellis_output),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .branch_metric      (branch_metric),
        .AlphaMetric        (AlphaMetric),
        .OldBetaMetric      (OldBetaMetric),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .BetaMetric         (BetaMetric),
        .llr_out            (llr_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int g_bm [NBM];
    int g_ob [STATES];
    int g_al [STATES];
    int g_ns [STATES][INSYM];
    int g_op [STATES][INSYM];

    logic [STATES*BITS-1:0] exp_beta_q [$];
    logic [INSYM*BITS-1:0]  exp_llr_q  [$];
    int                     acc_q      [$];

    bit   rdy_mode = 1'b0;
    logic rdy_val  = 1'b1;

    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic int sat(input int a, input int b);
        if (a == MINV || b == MINV) return MINV;
        if (a + b > MAXV) return MAXV;
        if (a + b < MINV) return MINV;
        return a + b;
    endfunction

    task automatic model(output logic [STATES*BITS-1:0] eb, output logic [INSYM*BITS-1:0] el);
        int beta [STATES];
        int llr  [INSYM];
        int m, b0;
        for (int u = 0; u < INSYM; u++) llr[u] = MINV;
        for (int s = 0; s < STATES; s++) begin
            beta[s] = MINV;
            for (int u = 0; u < INSYM; u++) begin
                m = sat(g_bm[g_op[s][u]], g_ob[g_ns[s][u]]);
                if (m > beta[s]) beta[s] = m;
                if (sat(g_al[s], m) > llr[u]) llr[u] = sat(g_al[s], m);
            end
        end
`ifdef NORMALIZE_EN
        b0 = beta[0];
        for (int s = 0; s < STATES; s++) begin
            if (beta[s] != MINV) begin
                m = beta[s] - b0;
                beta[s] = (m > MAXV) ? MAXV : ((m < MINV) ? MINV : m);
            end
        end
`else
        b0 = 0;
`endif
        for (int s = 0; s < STATES; s++) eb[s*BITS +: BITS] = BITS'(beta[s]);
        for (int u = 0; u < INSYM; u++) el[u*BITS +: BITS] = BITS'(llr[u]);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NBM; i++) branch_metric[i*BITS +: BITS] = BITS'(g_bm[i]);
        for (int s = 0; s < STATES; s++) begin
            AlphaMetric[s*BITS +: BITS]   = BITS'(g_al[s]);
            OldBetaMetric[s*BITS +: BITS] = BITS'(g_ob[s]);
            for (int u = 0; u < INSYM; u++) begin
                trellis_next_state[(s*INSYM+u)*SW +: SW]   = SW'(g_ns[s][u]);
                trellis_output[(s*INSYM+u)*NOUT +: NOUT]   = NOUT'(g_op[s][u]);
            end
        end
    endtask

    // Recursive systematic code, feedback 7, feedforward 5; state = {d1,d2}.
    task automatic build_rsc();
        int d1, d2, a;
        for (int s = 0; s < STATES; s++) begin
            for (int u = 0; u < INSYM; u++) begin
                d1 = (s >> 1) & 1;
                d2 = s & 1;
                a  = u ^ d1 ^ d2;
                g_ns[s][u] = (a << 1) | d1;
                g_op[s][u] = (u << 1) | (a ^ d2);
            end
        end
    endtask

    task automatic rand_trellis();
        for (int s = 0; s < STATES; s++)
            for (int u = 0; u < INSYM; u++) begin
                g_ns[s][u] = int'($urandom_range(0, STATES - 1));
                g_op[s][u] = int'($urandom_range(0, NBM - 1));
            end
    endtask

    function automatic int rnd_metric();
        case ($urandom_range(0, 9))
            0:       return MINV;
            1:       return MAXV;
            2, 3:    return int'($urandom_range(0, 200)) - 100;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic fill(input int bm, input int ob, input int al);
        for (int i = 0; i < NBM; i++) g_bm[i] = bm;
        for (int s = 0; s < STATES; s++) begin
            g_ob[s] = ob;
            g_al[s] = al;
        end
    endtask

    task automatic rand_fill();
        for (int i = 0; i < NBM; i++) g_bm[i] = rnd_metric();
        for (int s = 0; s < STATES; s++) begin
            g_ob[s] = rnd_metric();
            g_al[s] = rnd_metric();
        end
    endtask

    task automatic send(output int acc_cyc);
        logic [STATES*BITS-1:0] eb;
        logic [INSYM*BITS-1:0]  el;
        bit ok;
        model(eb, el);
        drive_inputs();
        in_valid = 1'b1;
        ok = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_beta_q.push_back(eb);
                exp_llr_q.push_back(el);
                acc_cyc = cyc + 1;
                acc_q.push_back(cyc + 1);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) flag("accept_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_beta_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_beta_q.size() != 0) flag("drain_timeout");
    endtask

    // Monitor: latency, hold-while-stalled and scoreboard comparison.
    logic                   prev_v = 1'b0;
    logic                   prev_r = 1'b0;
    logic [STATES*BITS-1:0] held_b = '0;
    logic [INSYM*BITS-1:0]  held_l = '0;
    int                     mon_acc;

    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    flag("valid_without_accept");
                end else begin
                    mon_acc = acc_q.pop_front();
                    chk("latency", 64'(cyc - mon_acc), 64'(LAT));
                end
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_beta", 64'(BetaMetric), 64'(held_b));
                chk("hold_llr", 64'(llr_out), 64'(held_l));
            end
            if (out_valid && !out_ready) chk("in_ready_blocked", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (exp_beta_q.size() == 0) begin
                    flag("unexpected_output");
                end else begin
                    chk("beta", 64'(BetaMetric), 64'(exp_beta_q.pop_front()));
                    chk("llr", 64'(llr_out), 64'(exp_llr_q.pop_front()));
                end
            end
            prev_v = out_valid;
            prev_r = out_ready;
            held_b = BetaMetric;
            held_l = llr_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        bit saw_valid;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_beta", 64'(BetaMetric), 64'(0));
        chk("rst_llr", 64'(llr_out), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        build_rsc();
        fill(5, 3, 13);
        send(a1);
        wait_idle();

        fill(5, 3, MINV);
        g_al[2] = 13;
        send(a1);
        wait_idle();

        fill(MAXV, 100, 0);
        send(a1);
        fill(MINV, 100, 0);
        send(a1);
        wait_idle();

`ifdef NORMALIZE_EN
        fill(5, 3, 13);
        g_ob[0] = 8;
        send(a1);
        wait_idle();
`endif

        // Back-to-back steps with the sink always ready.
        rand_fill();
        send(a1);
        rand_fill();
        send(a2);
        chk("throughput", 64'(a2 - a1), 64'(LAT + 1));
        wait_idle();

        // Stalled output with a competing in_valid pulse.
        rdy_val = 1'b0;
        rand_fill();
        send(a1);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        if (!out_valid) flag("stall_wait_valid");
        @(posedge clk);
        #1;
        rand_fill();
        drive_inputs();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rdy_val = 1'b1;
        wait_idle();
        repeat (LAT + 4) @(negedge clk);
        chk("no_second_accept", 64'(out_valid), 64'(0));
        chk("no_second_pending", 64'(acc_q.size()), 64'(0));
        @(posedge clk);
        #1;

        // Reset during the second cycle of RUN aborts the step.
        rand_fill();
        send(a1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_beta_q.delete();
        exp_llr_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        saw_valid = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_output", 64'(saw_valid), 64'(0));
        @(posedge clk);
        #1;
        rand_fill();
        send(a1);
        wait_idle();

        // Randomised steps, random tables and back-pressure.
        for (int n = 0; n < 40; n++) begin
            rdy_mode = (n >= 10);
            if ($urandom_range(0, 1) == 1) rand_trellis();
            else build_rsc();
            rand_fill();
            send(a1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_beta_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
